free_mode: RTL and testbench

FREE_MODE -- requirements
Module: free_mode

---
 rtl/free_mode.sv | 148 ++++++++++++++
 tb/tb_free_mode.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/free_mode.sv
// Single-key square-wave tone generator with three-octave selection.
// pwm/sd are registered; tone or octave changes restart the half-period on the next edge.
module free_mode #(
  parameter int unsigned CLK_HZ = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] buts,
  input  logic       but_up,
  input  logic       but_center,
  input  logic       but_down,
  output logic       pwm,
  output logic       sd,
  output logic [1:0] octave
);

  // fc is the note frequency in hundredths of a Hz; the 100 MHz table is pinned exactly.
  function automatic longint unsigned half_cnt(input longint unsigned fc,
                                               input longint unsigned ref100);
    longint unsigned hz;
    hz = 64'(CLK_HZ);
    if (CLK_HZ == 32'd100000000) return ref100;
    return (hz * 64'd100 + fc) / (64'd2 * fc);
  endfunction

  localparam longint unsigned C_MID = half_cnt(64'd26163, 64'd191110);
  localparam int CW_NEED = $clog2(64'd2 * C_MID + 64'd1);
  localparam int CW      = (CW_NEED > 20) ? CW_NEED : 20;

  localparam logic [CW-1:0] MID_C  = CW'(half_cnt(64'd26163, 64'd191110));
  localparam logic [CW-1:0] MID_D  = CW'(half_cnt(64'd29366, 64'd170264));
  localparam logic [CW-1:0] MID_E  = CW'(half_cnt(64'd32963, 64'd151685));
  localparam logic [CW-1:0] MID_F  = CW'(half_cnt(64'd34923, 64'd143172));
  localparam logic [CW-1:0] MID_G  = CW'(half_cnt(64'd39200, 64'd127551));
  localparam logic [CW-1:0] MID_A  = CW'(half_cnt(64'd44000, 64'd113636));
  localparam logic [CW-1:0] MID_B  = CW'(half_cnt(64'd49388, 64'd101239));
  localparam logic [CW-1:0] MID_C2 = CW'(half_cnt(64'd52325, 64'd95556));

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pwm_q, pwm_d;
  logic          sd_q, sd_d;
  logic [1:0]    octave_q, octave_d;
  logic          tone_on_q, tone_on_d;
  logic [2:0]    tone_key_q, tone_key_d;
  logic [1:0]    tone_oct_q, tone_oct_d;

  logic          key_vld;
  logic [2:0]    key_idx;
  logic [CW-1:0] mid_cnt;
  logic [CW-1:0] half;
  logic          restart;

  // Descending scan so the lowest-index held key wins.
  always_comb begin
    key_vld = |buts;
    key_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (buts[i]) key_idx = 3'(i);
    end
  end

  always_comb begin
    case (tone_key_q)
      3'd0:    mid_cnt = MID_C;
      3'd1:    mid_cnt = MID_D;
      3'd2:    mid_cnt = MID_E;
      3'd3:    mid_cnt = MID_F;
      3'd4:    mid_cnt = MID_G;
      3'd5:    mid_cnt = MID_A;
      3'd6:    mid_cnt = MID_B;
      default: mid_cnt = MID_C2;
    endcase
  end

  always_comb begin
    case (tone_oct_q)
      2'd0:    half = {mid_cnt[CW-2:0], 1'b0};
      2'd2:    half = {1'b0, mid_cnt[CW-1:1]};
      default: half = mid_cnt;
    endcase
  end

  assign restart = key_vld &&
                   (!tone_on_q || (key_idx != tone_key_q) || (octave_q != tone_oct_q));

  always_comb begin
    cnt_d      = cnt_q;
    pwm_d      = pwm_q;
    sd_d       = sd_q;
    tone_on_d  = tone_on_q;
    tone_key_d = tone_key_q;
    tone_oct_d = tone_oct_q;
    if (!key_vld) begin
      cnt_d     = '0;
      pwm_d     = 1'b0;
      sd_d      = 1'b0;
      tone_on_d = 1'b0;
    end else if (restart) begin
      cnt_d      = '0;
      pwm_d      = 1'b0;
      sd_d       = 1'b1;
      tone_on_d  = 1'b1;
      tone_key_d = key_idx;
      tone_oct_d = octave_q;
    end else if (cnt_q == half - CW'(1)) begin
      cnt_d = '0;
      pwm_d = ~pwm_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_comb begin
    octave_d = octave_q;
    if (but_center) begin
      octave_d = 2'd1;
    end else if (but_up && !but_down) begin
      if (octave_q < 2'd2) octave_d = octave_q + 2'd1;
    end else if (but_down && !but_up) begin
      if (octave_q > 2'd0) octave_d = octave_q - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      pwm_q      <= 1'b0;
      sd_q       <= 1'b0;
      octave_q   <= 2'd1;
      tone_on_q  <= 1'b0;
      tone_key_q <= 3'd0;
      tone_oct_q <= 2'd1;
    end else begin
      cnt_q      <= cnt_d;
      pwm_q      <= pwm_d;
      sd_q       <= sd_d;
      octave_q   <= octave_d;
      tone_on_q  <= tone_on_d;
      tone_key_q <= tone_key_d;
      tone_oct_q <= tone_oct_d;
    end
  end

  assign pwm    = pwm_q;
  assign sd     = sd_q;
  assign octave = octave_q;

endmodule

// File: tb/tb_free_mode.sv
// Bench for free_mode at a scaled-down clock so tone periods stay short.
module tb_free_mode;
  localparam int unsigned TB_HZ = 100000;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] buts;
  logic       but_up, but_center, but_down;
  logic       pwm, sd;
  logic [1:0] octave;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  free_mode #(.CLK_HZ(TB_HZ)) dut (
    .clk(clk), .rst(rst), .buts(buts), .but_up(but_up), .but_center(but_center),
    .but_down(but_down), .pwm(pwm), .sd(sd), .octave(octave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  real freq [8] = '{261.63, 293.66, 329.63, 349.23, 392.00, 440.00, 493.88, 523.25};

  // Model state: tone described by start time and note, not by a counter.
  int m_oct, m_key, m_toct, m_t;
  bit m_on, m_pwm, m_sd;

  function automatic int model_half(input int key, input int oct);
    int mid;
    mid = $rtoi(TB_HZ / (2.0 * freq[key]) + 0.5);
    if (oct == 0) return mid * 2;
    if (oct == 2) return mid / 2;
    return mid;
  endfunction

  task automatic model_step();
    int key;
    key = -1;
    for (int i = 0; i < 8; i++) if (buts[i] && key < 0) key = i;
    if (key < 0) begin
      m_on = 0; m_pwm = 0; m_sd = 0;
    end else if (!m_on || key != m_key || m_oct != m_toct) begin
      m_on = 1; m_key = key; m_toct = m_oct; m_t = 0; m_pwm = 0; m_sd = 1;
    end else begin
      m_t++;
      m_pwm = ((m_t / model_half(m_key, m_toct)) % 2) == 1;
    end
    if (but_center) m_oct = 1;
    else if (but_up && !but_down) m_oct = (m_oct < 2) ? m_oct + 1 : 2;
    else if (but_down && !but_up) m_oct = (m_oct > 0) ? m_oct - 1 : 0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_oct = 1; m_on = 0; m_pwm = 0; m_sd = 0; m_key = 0; m_toct = 1; m_t = 0;
    end else begin
      model_step();
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("model_pwm", int'(pwm), int'(m_pwm));
      chk("model_sd", int'(sd), int'(m_sd));
      chk("model_octave", int'(octave), m_oct);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit up, input bit ctr, input bit dn);
    but_up = up; but_center = ctr; but_down = dn;
    tick();
    but_up = 0; but_center = 0; but_down = 0;
  endtask

  task automatic wait_toggle(input string nm, output int at);
    logic prev;
    prev = pwm;
    at = cyc;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (pwm !== prev) begin
        at = cyc;
        return;
      end
    end
    chk({nm, "_timeout"}, 0, 1);
  endtask

  int t0, t1, t2, t3, t4;

  initial begin
    rst = 1; buts = 8'h00; but_up = 0; but_center = 0; but_down = 0;
    tick(); tick();
    chk("rst_octave", int'(octave), 1);
    chk("rst_pwm", int'(pwm), 0);
    chk("rst_sd", int'(sd), 0);
    rst = 0;
    tick();

    // C held: half-period 191 at this clock
    buts = 8'h01; tick(); t0 = cyc;
    chk("c_sd_on", int'(sd), 1);
    chk("c_pwm_start", int'(pwm), 0);
    wait_toggle("c1", t1); chk("c_first", t1 - t0, 191);
    wait_toggle("c2", t2); chk("c_half", t2 - t1, 191);
    wait_toggle("c3", t3); chk("c_period", t3 - t1, 382);

    // C and E held: C still wins, no restart
    buts = 8'h05;
    wait_toggle("ce", t4); chk("ce_keep_c", t4 - t3, 191);
    buts = 8'h04; tick(); t0 = cyc;
    chk("e_restart_pwm", int'(pwm), 0);
    wait_toggle("e1", t1); chk("e_first", t1 - t0, 152);
    wait_toggle("e2", t2); chk("e_half", t2 - t1, 152);

    buts = 8'h00; tick();
    chk("off_pwm", int'(pwm), 0);
    chk("off_sd", int'(sd), 0);
    repeat (1000) tick();
    chk("off_sd_held", int'(sd), 0);

    pulse(1, 0, 0); chk("up1", int'(octave), 2);
    pulse(1, 0, 0); chk("up2", int'(octave), 2);
    pulse(1, 0, 0); chk("up3", int'(octave), 2);
    buts = 8'h20; tick(); t0 = cyc;
    wait_toggle("a_hi", t1); chk("a_high", t1 - t0, 57);

    buts = 8'h00; tick();
    pulse(0, 0, 1); chk("dn1", int'(octave), 1);
    pulse(0, 0, 1); chk("dn2", int'(octave), 0);
    pulse(0, 0, 1); chk("dn3", int'(octave), 0);
    buts = 8'h20; tick(); t0 = cyc;
    wait_toggle("a_lo", t1); chk("a_low", t1 - t0, 228);

    // octave change while A sounds restarts at the edge after octave updates
    pulse(1, 0, 0); chk("a_oct_mid", int'(octave), 1);
    tick(); t0 = cyc;
    chk("a_oct_restart", int'(pwm), 0);
    wait_toggle("a_mid", t1); chk("a_mid", t1 - t0, 114);

    buts = 8'h00; tick();
    pulse(1, 0, 1); chk("updn_same", int'(octave), 1);
    pulse(1, 0, 0); chk("up_again", int'(octave), 2);
    pulse(0, 1, 1); chk("ctr_over_dn", int'(octave), 1);

    // async reset mid-tone at octave 0
    pulse(0, 0, 1); chk("pre_rst_oct", int'(octave), 0);
    buts = 8'h01; tick();
    wait_toggle("lo_c", t1);
    chk("pre_rst_pwm", int'(pwm), 1);
    rst = 1; #1;
    chk("arst_pwm", int'(pwm), 0);
    chk("arst_sd", int'(sd), 0);
    chk("arst_oct", int'(octave), 1);
    tick(); tick();
    rst = 0;
    tick(); t0 = cyc;
    chk("post_rst_sd", int'(sd), 1);
    wait_toggle("post", t1); chk("post_rst_mid", t1 - t0, 191);

    buts = 8'h00; tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
